// File: rtl/xtensa_reset_pkg.sv
// ---------------------------------------------------------------------------
// xtensa_reset_pkg
// Shared types and default constants for the core-side Xtensa reset path.
//
// Contents:
//   seq_state_e      - reset sequencer states (2-bit encoding, visible on the
//                      debug port so the numeric values are fixed)
//   XT_SYNC_STAGES   - default depth of the reset-release synchronizer
//   XT_HOLD_CYCLES   - default number of CLK edges BReset is held after release
//   XT_DRAIN_TIMEOUT - default limit on how long we wait for the core to idle
//   XT_CNT_W         - default width of the shared hold/drain counter
// ---------------------------------------------------------------------------
package xtensa_reset_pkg;

  // The numeric values are observed by debug tooling through seq_state,
  // so they are pinned explicitly rather than left to enum defaults.
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_QUIESCE = 2'd3
  } seq_state_e;

  localparam int XT_SYNC_STAGES   = 2;
  localparam int XT_HOLD_CYCLES   = 100;
  localparam int XT_DRAIN_TIMEOUT = 16;
  localparam int XT_CNT_W         = 16;

endpackage

// File: rtl/reset_sync.sv
// ---------------------------------------------------------------------------
// reset_sync
// Generic N-stage reset synchronizer: assertion is asynchronous (all stages
// clear the moment rst_n falls), release is synchronous (a 1 has to walk
// through every stage before 'released' goes high).
//
// Parameters:
//   STAGES   - number of flops in the chain, at least 2
// Ports:
//   CLK      in   clock of the domain being released
//   rst_n    in   asynchronous active-low reset
//   released out  high once rst_n has been high for STAGES edges
// ---------------------------------------------------------------------------
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic rst_n,
  output logic released
);

  logic [STAGES-1:0] chain;

  // Shift a constant 1 in from the bottom; the top bit is the
  // synchronized release. Any glitch low on rst_n empties the chain
  // again, so a short pulse always restarts the full release delay.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign released = chain[STAGES-1];

endmodule

// File: rtl/xtensa_reset_seq.sv
// ---------------------------------------------------------------------------
// xtensa_reset_seq
// Core-side reset sequencer for the Xtensa. Produces the core's active-high
// BReset from the board reset (asynchronous assertion, synchronized and
// counted release) and services software reset requests. Before a software
// reset the core is stalled with RunStall and given a bounded time to drain
// so that BReset never lands in the middle of a bus transaction.
//
// Parameters:
//   SYNC_STAGES   - release synchronizer depth (>= 2)
//   HOLD_CYCLES   - CLK edges BReset stays high once release starts (>= 1)
//   DRAIN_TIMEOUT - max cycles spent waiting for core_idle (>= 1)
//   CNT_W         - width of the shared counter; must hold both limits
// Ports:
//   CLK           in   core clock
//   BResetN       in   board reset, asynchronous, active low
//   sw_rst_req    in   software reset request (level, held until ack)
//   sw_rst_ack    out  one-cycle pulse when the request is taken
//   core_idle     in   core is quiescent, sampled on CLK
//   RunStall      out  stall to the core while draining
//   BReset        out  active-high reset to the core
//   rst_done      out  one-cycle pulse on the cycle BReset falls
//   drain_timeout out  sticky: the last drain ended by timeout
//   seq_state     out  current sequencer state, for debug
// ---------------------------------------------------------------------------
module xtensa_reset_seq
  import xtensa_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = XT_SYNC_STAGES,
  parameter int HOLD_CYCLES   = XT_HOLD_CYCLES,
  parameter int DRAIN_TIMEOUT = XT_DRAIN_TIMEOUT,
  parameter int CNT_W         = XT_CNT_W
) (
  input  logic       CLK,
  input  logic       BResetN,
  input  logic       sw_rst_req,
  output logic       sw_rst_ack,
  input  logic       core_idle,
  output logic       RunStall,
  output logic       BReset,
  output logic       rst_done,
  output logic       drain_timeout,
  output logic [1:0] seq_state
);

  // Terminal counts are compared against the counter's current value, so
  // the transition happens on the edge after the counter shows N-1.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             sync_released;

  // Board reset release is synchronized here; software resets go straight
  // from QUIESCE to HOLD and never touch this chain.
  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK      (CLK),
    .rst_n    (BResetN),
    .released (sync_released)
  );

  // Single sequencer FSM. One counter is shared between HOLD (release
  // delay) and QUIESCE (drain timeout) because the two never overlap.
  // BReset is a flop with an asynchronous set, which gives the immediate
  // assertion on BResetN falling while every output remains registered.
  always_ff @(posedge CLK or negedge BResetN) begin
    if (!BResetN) begin
      state         <= ST_ASSERT;
      cnt           <= '0;
      BReset        <= 1'b1;
      RunStall      <= 1'b0;
      sw_rst_ack    <= 1'b0;
      rst_done      <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      rst_done   <= 1'b0;

      case (state)
        ST_ASSERT: begin
          BReset   <= 1'b1;
          RunStall <= 1'b0;
          if (sync_released) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end

        ST_HOLD: begin
          BReset   <= 1'b1;
          RunStall <= 1'b0;
          if (cnt == HOLD_LAST) begin
            state    <= ST_RUN;
            cnt      <= '0;
            BReset   <= 1'b0;
            rst_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RUN: begin
          BReset   <= 1'b0;
          RunStall <= 1'b0;
          // Requests seen in other states are simply left pending; the
          // requester holds the level, so it is picked up here later.
          if (sw_rst_req) begin
            state      <= ST_QUIESCE;
            cnt        <= '0;
            RunStall   <= 1'b1;
            sw_rst_ack <= 1'b1;
          end
        end

        ST_QUIESCE: begin
          BReset   <= 1'b0;
          RunStall <= 1'b1;
          // Idle takes priority over the timeout on the same edge, which
          // is why the sticky flag is derived from core_idle alone.
          if (core_idle || (cnt == DRAIN_LAST)) begin
            state         <= ST_HOLD;
            cnt           <= '0;
            BReset        <= 1'b1;
            RunStall      <= 1'b0;
            drain_timeout <= !core_idle;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= ST_ASSERT;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_xtensa_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_xtensa_reset_seq
// Self-checking bench for xtensa_reset_seq. Scenario tasks drive the inputs
// and, from the timing rules of the sequencer, compute the edge on which each
// visible output event must appear (ack pulse, stall rise/fall, BReset
// rise/fall, done pulse). Those events are queued; an independent monitor
// watches the outputs on the falling clock edge, turns every change into an
// event and compares it with the head of the queue.
// ---------------------------------------------------------------------------
module tb_xtensa_reset_seq;

  localparam int SYNC  = 2;
  localparam int HOLD  = 100;
  localparam int DRAIN = 16;
  localparam int CW    = 16;

  localparam int EV_ACK        = 1;
  localparam int EV_STALL_RISE = 2;
  localparam int EV_STALL_FALL = 3;
  localparam int EV_BR_RISE    = 4;
  localparam int EV_BR_FALL    = 5;
  localparam int EV_DONE       = 6;

  typedef struct {
    int kind;
    int at;
    int aux;
  } ev_t;

  logic       CLK;
  logic       BResetN;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic       core_idle;
  logic       RunStall;
  logic       BReset;
  logic       rst_done;
  logic       drain_timeout;
  logic [1:0] seq_state;

  ev_t expQ[$];
  int  edgeNo;
  int  checkCount;
  int  passCount;
  int  runFrom;

  xtensa_reset_seq #(
    .SYNC_STAGES   (SYNC),
    .HOLD_CYCLES   (HOLD),
    .DRAIN_TIMEOUT (DRAIN),
    .CNT_W         (CW)
  ) dut (
    .CLK           (CLK),
    .BResetN       (BResetN),
    .sw_rst_req    (sw_rst_req),
    .sw_rst_ack    (sw_rst_ack),
    .core_idle     (core_idle),
    .RunStall      (RunStall),
    .BReset        (BReset),
    .rst_done      (rst_done),
    .drain_timeout (drain_timeout),
    .seq_state     (seq_state)
  );

  // Free-running clock; edge numbering starts at 0 for the first rise.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial edgeNo = -1;
  always @(posedge CLK) edgeNo <= edgeNo + 1;

  // Shared comparison helper used by both the monitor and the scenarios.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edgeNo);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic idle);
    sw_rst_req = req;
    core_idle  = idle;
  endtask

  // Returns 2 time units after the rising edge numbered e (e must be ahead
  // of the current edge); inputs driven then are sampled at edge e+1.
  task automatic waitEdge(input int e);
    do begin
      @(posedge CLK);
      #2;
    end while (edgeNo < e);
  endtask

  function automatic void pushExp(input int kind, input int at, input int aux);
    ev_t ev;
    ev.kind = kind;
    ev.at   = at;
    ev.aux  = aux;
    expQ.push_back(ev);
  endfunction

  // Reference timeline of a software reset accepted at edge n when the core
  // first reports idle k edges later. The stall can last at most DRAIN
  // cycles; reaching that limit without idle sets the sticky flag. BReset is
  // then held for HOLD edges and rst_done coincides with RUN being reached.
  // upto: 0 = acceptance only, 1 = through BReset rise, 2 = full sequence.
  function automatic int pushSoft(input int n, input int k, input int upto);
    int q;
    int rise;
    int fall;
    q    = (k < DRAIN) ? k : DRAIN;
    rise = n + q;
    fall = rise + HOLD;
    pushExp(EV_ACK, n, 0);
    pushExp(EV_STALL_RISE, n, 0);
    if (upto >= 1) begin
      pushExp(EV_STALL_FALL, rise, 0);
      pushExp(EV_BR_RISE, rise, (k > DRAIN) ? 1 : 0);
    end
    if (upto >= 2) begin
      pushExp(EV_BR_FALL, fall, 0);
      pushExp(EV_DONE, fall, 2);
    end
    return fall;
  endfunction

  task automatic checkDrained(input string name);
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  // Caller has raised sw_rst_req after edge n-1. Drops it after the ack and
  // keeps core_idle low until the k-th drain edge (never, past the limit).
  task automatic driveQuiesce(input int n, input int k);
    int last;
    last = (k < DRAIN) ? k : DRAIN;
    for (int j = 1; j <= last; j++) begin
      waitEdge(n + j - 1);
      applyStimulus(1'b0, (j == k) ? 1'b1 : 1'b0);
    end
  endtask

  // Board reset pulse from the current point in the cycle. brWasLow and
  // stallWasHigh describe what the core currently sees, so the bench knows
  // which asynchronous output changes to expect. Returns the edge on which
  // BReset must fall: SYNC edges to fill the chain plus HOLD edges.
  task automatic asyncReset(input bit brWasLow, input bit stallWasHigh,
                            input int lowEdges, output int fall);
    int e;
    int r;
    e       = edgeNo;
    BResetN = 1'b0;
    if (stallWasHigh) pushExp(EV_STALL_FALL, e, 0);
    if (brWasLow) pushExp(EV_BR_RISE, e, 0);
    #1;
    checkOutput("async_breset", int'(BReset), 1);
    checkOutput("async_runstall", int'(RunStall), 0);
    waitEdge(e + lowEdges);
    BResetN = 1'b1;
    r    = edgeNo + 1;
    fall = r + SYNC + HOLD;
    pushExp(EV_BR_FALL, fall, 0);
    pushExp(EV_DONE, fall, 2);
  endtask

  task automatic powerOn();
    int r;
    int fall;
    applyStimulus(1'b0, 1'b0);
    #1 BResetN = 1'b0;
    @(negedge CLK);
    #1;
    checkOutput("rst_breset", int'(BReset), 1);
    checkOutput("rst_runstall", int'(RunStall), 0);
    checkOutput("rst_ack", int'(sw_rst_ack), 0);
    checkOutput("rst_done", int'(rst_done), 0);
    checkOutput("rst_drain_timeout", int'(drain_timeout), 0);
    checkOutput("rst_state", int'(seq_state), 0);
    waitEdge(2);
    BResetN = 1'b1;
    r    = edgeNo + 1;
    fall = r + SYNC + HOLD;
    pushExp(EV_BR_FALL, fall, 0);
    pushExp(EV_DONE, fall, 2);
    waitEdge(r + SYNC - 1);
    checkOutput("sync_filling_state", int'(seq_state), 0);
    waitEdge(r + SYNC);
    checkOutput("hold_state", int'(seq_state), 1);
    waitEdge(fall + 1);
    checkDrained("poweron_drained");
    runFrom = fall;
  endtask

  task automatic softReset(input int k, input int gap);
    int n;
    int fall;
    for (int g = 0; g < gap; g++) begin
      waitEdge(edgeNo + 1);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    n    = edgeNo + 1;
    fall = pushSoft(n, k, 2);
    driveQuiesce(n, k);
    waitEdge(fall + 1);
    checkDrained("soft_drained");
    runFrom = fall;
  endtask

  task automatic midHoldReset();
    int n;
    int fall;
    applyStimulus(1'b1, 1'b0);
    n = edgeNo + 1;
    void'(pushSoft(n, 1, 1));
    driveQuiesce(n, 1);
    // Counter shows 50 after the 50th edge following the BReset rise.
    waitEdge(n + 1 + 50);
    asyncReset(1'b0, 1'b0, 1, fall);
    waitEdge(fall + 1);
    checkDrained("midhold_drained");
    runFrom = fall;
  endtask

  task automatic earlyRequest();
    int f;
    int n;
    int fall;
    applyStimulus(1'b1, 1'b1);
    asyncReset(1'b1, 1'b0, 2, f);
    n    = f + 1;
    fall = pushSoft(n, 1, 2);
    waitEdge(f);
    driveQuiesce(n, 1);
    waitEdge(fall + 1);
    checkDrained("early_drained");
    runFrom = fall;
  endtask

  task automatic quiesceAsync();
    int n;
    int fall;
    applyStimulus(1'b1, 1'b0);
    n = edgeNo + 1;
    void'(pushSoft(n, DRAIN + 5, 0));
    waitEdge(n);
    applyStimulus(1'b0, 1'b0);
    waitEdge(n + 2);
    asyncReset(1'b1, 1'b1, 2, fall);
    waitEdge(fall + 1);
    checkDrained("quiesce_async_drained");
    runFrom = fall;
  endtask

  // Monitor: every observed output change becomes an event that must match
  // the oldest outstanding expectation in kind, edge and side value.
  task automatic observe(input int kind, input int aux);
    ev_t ev;
    if (expQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL unexpected_event: got kind %0d at edge %0d, required no event", kind, edgeNo);
    end else begin
      ev = expQ.pop_front();
      checkOutput("ev_kind", kind, ev.kind);
      checkOutput("ev_edge", edgeNo, ev.at);
      checkOutput("ev_aux", aux, ev.aux);
    end
  endtask

  initial begin : monitor
    logic pBR;
    logic pST;
    pBR = 1'b1;
    pST = 1'b0;
    forever begin
      @(negedge CLK);
      if (sw_rst_ack) observe(EV_ACK, 0);
      if (RunStall && !pST) observe(EV_STALL_RISE, 0);
      if (!RunStall && pST) observe(EV_STALL_FALL, 0);
      if (BReset && !pBR) observe(EV_BR_RISE, int'(drain_timeout));
      if (!BReset && pBR) observe(EV_BR_FALL, 0);
      if (rst_done) observe(EV_DONE, int'(seq_state));
      pBR = BReset;
      pST = RunStall;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    runFrom    = 0;
    BResetN    = 1'b1;
    applyStimulus(1'b0, 1'b0);

    powerOn();
    softReset(1, 0);
    softReset(DRAIN + 1 + int'($urandom_range(0, 3)), 1);
    softReset(1, 2);
    softReset(DRAIN, 0);
    softReset(DRAIN + 1, 0);
    for (int i = 0; i < 5; i++) begin
      softReset(int'($urandom_range(1, DRAIN + 4)), int'($urandom_range(0, 4)));
    end
    midHoldReset();
    earlyRequest();
    quiesceAsync();
    softReset(1, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
